// File: rtl/test_001_pkg.sv
// Shared definitions for test_001: FSM states, method indices, loop modes,
// switch_test constants, the acc4 threshold and the self-test vectors.
package test_001_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE             = 4'd0;
   localparam state_t ST_EXEC_ACC         = 4'd1;
   localparam state_t ST_EXEC_ADD         = 4'd2;
   localparam state_t ST_EXEC_ADD2        = 4'd3;
   localparam state_t ST_EXEC_ACC2        = 4'd4;
   localparam state_t ST_EXEC_ACC3        = 4'd5;
   localparam state_t ST_EXEC_ACC4        = 4'd6;
   localparam state_t ST_EXEC_SWITCH_TEST = 4'd7;
   localparam state_t ST_EXEC_TEST        = 4'd8;
   localparam state_t ST_DONE             = 4'd9;

   localparam int M_ACC  = 0;
   localparam int M_ADD  = 1;
   localparam int M_ADD2 = 2;
   localparam int M_ACC2 = 3;
   localparam int M_ACC3 = 4;
   localparam int M_ACC4 = 5;
   localparam int M_SW   = 6;
   localparam int M_TEST = 7;

   typedef enum logic [1:0] {LOOP_ACC2, LOOP_ACC3, LOOP_ACC4} loop_mode_e;

   localparam logic signed [31:0] SW_VAL_0       = 32'sd10;
   localparam logic signed [31:0] SW_VAL_1       = 32'sd20;
   localparam logic signed [31:0] SW_VAL_2       = 32'sd30;
   localparam logic signed [31:0] SW_VAL_OTHER   = 32'hFFFF_FFFF;
   localparam logic signed [31:0] ACC4_THRESHOLD = 32'sd1000;

   // Built-in self-test call arguments and their expected results
   localparam logic signed [31:0] T_ACC_Y    = 32'sd5;
   localparam logic signed [31:0] T_ACC2_NUM = 32'sd3;
   localparam logic signed [31:0] T_ACC2_Y   = 32'sd2;
   localparam logic signed [31:0] T_ACC3_NUM = 32'sd3;
   localparam logic signed [31:0] T_ACC3_Y   = 32'sd1;
   localparam logic signed [31:0] T_ACC4_NUM = 32'sd4;
   localparam logic signed [31:0] T_ACC4_Y   = 32'sd3;
   localparam logic signed [31:0] T_ADD_X    = 32'sd2;
   localparam logic signed [31:0] T_ADD_Y    = 32'sd3;
   localparam logic signed [31:0] T_SW_A     = 32'sd1;
   localparam logic signed [31:0] T_SW_B     = 32'sd7;

   localparam logic signed [31:0] EXP_ACC  = 32'sd5;
   localparam logic signed [31:0] EXP_ACC2 = 32'sd11;
   localparam logic signed [31:0] EXP_ACC3 = 32'sd17;
   localparam logic signed [31:0] EXP_ACC4 = 32'sd29;
   localparam logic signed [31:0] EXP_ADD  = 32'sd5;
   localparam logic signed [31:0] EXP_ADD2 = 32'sd8;
   localparam logic signed [31:0] EXP_SW_A = 32'sd20;
   localparam logic signed [31:0] EXP_SW_B = 32'hFFFF_FFFF;

   function automatic logic signed [31:0] switch_value(input logic signed [31:0] x);
      case (x)
         32'sd0:  return SW_VAL_0;
         32'sd1:  return SW_VAL_1;
         32'sd2:  return SW_VAL_2;
         default: return SW_VAL_OTHER;
      endcase
   endfunction

   function automatic logic signed [31:0] add2_value(input logic signed [31:0] x,
                                                     input logic signed [31:0] y);
      return x + (y <<< 1);
   endfunction

endpackage

// File: rtl/test_001_loop_unit.sv
// Iteration engine for acc2/acc3/acc4: remaining-count down-counter, index,
// and the terminal / early-exit decision. The accumulator itself lives in the top.
module test_001_loop_unit
   import test_001_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  loop_mode_e         mode,
   input  logic signed [31:0] num,
   input  logic signed [31:0] y,
   input  logic signed [31:0] x_cur,
   output logic signed [31:0] x_next,
   output logic               last
);

   logic [31:0]        rem_q;
   logic signed [31:0] idx_q;
   logic signed [31:0] y_q;
   logic signed [31:0] incr;
   loop_mode_e         mode_q;
   logic               empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q  <= '0;
         idx_q  <= '0;
         y_q    <= '0;
         mode_q <= LOOP_ACC2;
      end else if (load) begin
         rem_q  <= (num <= 32'sd0) ? '0 : $unsigned(num);
         idx_q  <= '0;
         y_q    <= y;
         mode_q <= mode;
      end else if (step && !empty) begin
         rem_q <= rem_q - 32'd1;
         idx_q <= idx_q + 32'sd1;
      end
   end

   // An empty counter means num <= 0: one pass-through cycle, X untouched
   always_comb begin
      empty  = (rem_q == '0);
      incr   = (mode_q == LOOP_ACC3) ? (y_q + idx_q) : y_q;
      x_next = empty ? x_cur : (x_cur + incr);
      last   = empty || (rem_q == 32'd1) ||
               ((mode_q == LOOP_ACC4) && (x_next > ACC4_THRESHOLD));
   end

endmodule

// File: rtl/test_001.sv
// Method-call controller around one shared signed accumulator X.
// Optional simulation trace of the test() checks: define TEST_001_TRACE_EN.
//
// state               | meaning
// ST_IDLE             | no call running, arbitrate pending requests
// ST_EXEC_ACC..TEST   | executing the accepted method (loops stay here per iteration)
// ST_DONE             | publish result to the method's return port, drop busy
module test_001
   import test_001_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        acc_req,
   input  logic        add_req,
   input  logic        add2_req,
   input  logic        acc2_req,
   input  logic        acc3_req,
   input  logic        acc4_req,
   input  logic        switch_test_req,
   input  logic        test_req,
   input  logic [31:0] acc_y,
   input  logic [31:0] add_x,
   input  logic [31:0] add_y,
   input  logic [31:0] add2_x,
   input  logic [31:0] add2_y,
   input  logic [31:0] acc2_num,
   input  logic [31:0] acc2_y,
   input  logic [31:0] acc3_num,
   input  logic [31:0] acc3_y,
   input  logic [31:0] acc4_num,
   input  logic [31:0] acc4_y,
   input  logic [31:0] switch_test_x,
   output logic        acc_busy,
   output logic        add_busy,
   output logic        add2_busy,
   output logic        acc2_busy,
   output logic        acc3_busy,
   output logic        acc4_busy,
   output logic        switch_test_busy,
   output logic        test_busy,
   output logic [31:0] acc_return,
   output logic [31:0] add_return,
   output logic [31:0] add2_return,
   output logic [31:0] acc2_return,
   output logic [31:0] acc3_return,
   output logic [31:0] acc4_return,
   output logic [31:0] switch_test_return,
   output logic        test_return
);

   state_t             state_q;
   state_t             state_d;
   logic [7:0]         busy_q;
   logic [7:0]         accept_oh;
   logic signed [31:0] x_q;
   logic signed [31:0] res_q;
   logic signed [31:0] a_q;
   logic signed [31:0] b_q;
   logic signed [31:0] a_d;
   logic signed [31:0] b_d;
   logic [2:0]         tstep_q;
   logic               tphase_q;
   logic               tok_q;

   logic               lu_load;
   logic               lu_step;
   loop_mode_e         lu_mode;
   logic signed [31:0] lu_num;
   logic signed [31:0] lu_y;
   logic signed [31:0] lu_x_next;
   logic               lu_last;

   logic               chk_valid;
   logic signed [31:0] chk_act;
   logic signed [31:0] chk_exp;

   assign acc_busy         = busy_q[M_ACC];
   assign add_busy         = busy_q[M_ADD];
   assign add2_busy        = busy_q[M_ADD2];
   assign acc2_busy        = busy_q[M_ACC2];
   assign acc3_busy        = busy_q[M_ACC3];
   assign acc4_busy        = busy_q[M_ACC4];
   assign switch_test_busy = busy_q[M_SW];
   assign test_busy        = busy_q[M_TEST];

   // Arbitration in IDLE; during test() the loop unit is fed from the self-test vectors
   always_comb begin
      state_d   = ST_IDLE;
      accept_oh = '0;
      a_d       = '0;
      b_d       = '0;
      lu_load   = 1'b0;
      lu_mode   = LOOP_ACC2;
      lu_num    = '0;
      lu_y      = '0;
      if (state_q == ST_IDLE) begin
         if (test_req) begin
            state_d = ST_EXEC_TEST;  accept_oh[M_TEST] = 1'b1;
         end else if (acc_req) begin
            state_d = ST_EXEC_ACC;   accept_oh[M_ACC] = 1'b1;  a_d = acc_y;
         end else if (acc2_req) begin
            state_d = ST_EXEC_ACC2;  accept_oh[M_ACC2] = 1'b1;
            lu_load = 1'b1;  lu_mode = LOOP_ACC2;  lu_num = acc2_num;  lu_y = acc2_y;
         end else if (acc3_req) begin
            state_d = ST_EXEC_ACC3;  accept_oh[M_ACC3] = 1'b1;
            lu_load = 1'b1;  lu_mode = LOOP_ACC3;  lu_num = acc3_num;  lu_y = acc3_y;
         end else if (acc4_req) begin
            state_d = ST_EXEC_ACC4;  accept_oh[M_ACC4] = 1'b1;
            lu_load = 1'b1;  lu_mode = LOOP_ACC4;  lu_num = acc4_num;  lu_y = acc4_y;
         end else if (add_req) begin
            state_d = ST_EXEC_ADD;   accept_oh[M_ADD] = 1'b1;  a_d = add_x;  b_d = add_y;
         end else if (add2_req) begin
            state_d = ST_EXEC_ADD2;  accept_oh[M_ADD2] = 1'b1; a_d = add2_x; b_d = add2_y;
         end else if (switch_test_req) begin
            state_d = ST_EXEC_SWITCH_TEST;  accept_oh[M_SW] = 1'b1;  a_d = switch_test_x;
         end
      end else if ((state_q == ST_EXEC_TEST) && !tphase_q) begin
         case (tstep_q)
            3'd1: begin lu_load = 1'b1; lu_mode = LOOP_ACC2; lu_num = T_ACC2_NUM; lu_y = T_ACC2_Y; end
            3'd2: begin lu_load = 1'b1; lu_mode = LOOP_ACC3; lu_num = T_ACC3_NUM; lu_y = T_ACC3_Y; end
            3'd3: begin lu_load = 1'b1; lu_mode = LOOP_ACC4; lu_num = T_ACC4_NUM; lu_y = T_ACC4_Y; end
            default: ;
         endcase
      end
   end

   assign lu_step = (state_q == ST_EXEC_ACC2) || (state_q == ST_EXEC_ACC3) ||
                    (state_q == ST_EXEC_ACC4) || ((state_q == ST_EXEC_TEST) && tphase_q);

   // Self-test check of the current step: actual vs. expected result
   always_comb begin
      chk_valid = 1'b0;
      chk_act   = '0;
      chk_exp   = '0;
      if (state_q == ST_EXEC_TEST) begin
         case (tstep_q)
            3'd0: begin chk_valid = 1'b1; chk_act = T_ACC_Y; chk_exp = EXP_ACC; end
            3'd1: begin chk_valid = tphase_q && lu_last; chk_act = lu_x_next; chk_exp = EXP_ACC2; end
            3'd2: begin chk_valid = tphase_q && lu_last; chk_act = lu_x_next; chk_exp = EXP_ACC3; end
            3'd3: begin chk_valid = tphase_q && lu_last; chk_act = lu_x_next; chk_exp = EXP_ACC4; end
            3'd4: begin chk_valid = 1'b1; chk_act = T_ADD_X + T_ADD_Y; chk_exp = EXP_ADD; end
            3'd5: begin chk_valid = 1'b1; chk_act = add2_value(T_ADD_X, T_ADD_Y); chk_exp = EXP_ADD2; end
            3'd6: begin chk_valid = 1'b1; chk_act = switch_value(T_SW_A); chk_exp = EXP_SW_A; end
            default: begin chk_valid = 1'b1; chk_act = switch_value(T_SW_B); chk_exp = EXP_SW_B; end
         endcase
      end
   end

   test_001_loop_unit u_loop (
      .clk    (clk),
      .reset  (reset),
      .load   (lu_load),
      .step   (lu_step),
      .mode   (lu_mode),
      .num    (lu_num),
      .y      (lu_y),
      .x_cur  (x_q),
      .x_next (lu_x_next),
      .last   (lu_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= ST_IDLE;
         busy_q             <= '0;
         x_q                <= '0;
         res_q              <= '0;
         a_q                <= '0;
         b_q                <= '0;
         tstep_q            <= '0;
         tphase_q           <= 1'b0;
         tok_q              <= 1'b0;
         acc_return         <= '0;
         add_return         <= '0;
         add2_return        <= '0;
         acc2_return        <= '0;
         acc3_return        <= '0;
         acc4_return        <= '0;
         switch_test_return <= '0;
         test_return        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|accept_oh) begin
                  state_q  <= state_d;
                  busy_q   <= accept_oh;
                  a_q      <= a_d;
                  b_q      <= b_d;
                  tstep_q  <= '0;
                  tphase_q <= 1'b0;
                  tok_q    <= 1'b1;
               end
            end
            ST_EXEC_ACC: begin
               x_q     <= x_q + a_q;
               res_q   <= x_q + a_q;
               state_q <= ST_DONE;
            end
            ST_EXEC_ADD: begin
               res_q   <= a_q + b_q;
               state_q <= ST_DONE;
            end
            ST_EXEC_ADD2: begin
               res_q   <= add2_value(a_q, b_q);
               state_q <= ST_DONE;
            end
            ST_EXEC_SWITCH_TEST: begin
               res_q   <= switch_value(a_q);
               state_q <= ST_DONE;
            end
            ST_EXEC_ACC2, ST_EXEC_ACC3, ST_EXEC_ACC4: begin
               x_q   <= lu_x_next;
               res_q <= lu_x_next;
               if (lu_last) state_q <= ST_DONE;
            end
            ST_EXEC_TEST: begin
               if (chk_valid) tok_q <= tok_q & (chk_act == chk_exp);
               case (tstep_q)
                  3'd0: begin
                     x_q     <= T_ACC_Y;  // X := 0 followed by acc(5)
                     tstep_q <= 3'd1;
                  end
                  3'd1, 3'd2, 3'd3: begin
                     if (!tphase_q) begin
                        tphase_q <= 1'b1;
                     end else begin
                        x_q <= lu_x_next;
                        if (lu_last) begin
                           tphase_q <= 1'b0;
                           tstep_q  <= tstep_q + 3'd1;
                        end
                     end
                  end
                  3'd4, 3'd5, 3'd6: tstep_q <= tstep_q + 3'd1;
                  default: begin
                     res_q   <= {31'b0, tok_q & (chk_act == chk_exp)};
                     state_q <= ST_DONE;
                  end
               endcase
            end
            ST_DONE: begin
               if (busy_q[M_ACC])  acc_return         <= res_q;
               if (busy_q[M_ADD])  add_return         <= res_q;
               if (busy_q[M_ADD2]) add2_return        <= res_q;
               if (busy_q[M_ACC2]) acc2_return        <= res_q;
               if (busy_q[M_ACC3]) acc3_return        <= res_q;
               if (busy_q[M_ACC4]) acc4_return        <= res_q;
               if (busy_q[M_SW])   switch_test_return <= res_q;
               if (busy_q[M_TEST]) test_return        <= res_q[0];
               busy_q  <= '0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef TEST_001_TRACE_EN
   function automatic string check_name(input logic [2:0] s);
      case (s)
         3'd0:    return "acc(5)";
         3'd1:    return "acc2(3,2)";
         3'd2:    return "acc3(3,1)";
         3'd3:    return "acc4(4,3)";
         3'd4:    return "add(2,3)";
         3'd5:    return "add2(2,3)";
         3'd6:    return "switch_test(1)";
         default: return "switch_test(7)";
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!reset && chk_valid)
         $display("test_001 trace: %s expected=%0d actual=%0d",
                  check_name(tstep_q), chk_exp, chk_act);
   end
`endif

endmodule

// File: tb/tb_test_001.sv
// Scoreboard bench for test_001: randomized method calls checked against a
// behavioural model of the accumulator and the method rules.
module tb_test_001;

   localparam int ACC = 0, ADD = 1, ADD2 = 2, ACC2 = 3, ACC3 = 4, ACC4 = 5, SW = 6, TST = 7;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] req_v = '0;
   logic [7:0] busy_v;
   logic [31:0] acc_y = '0, add_x = '0, add_y = '0, add2_x = '0, add2_y = '0;
   logic [31:0] acc2_num = '0, acc2_y = '0, acc3_num = '0, acc3_y = '0;
   logic [31:0] acc4_num = '0, acc4_y = '0, switch_test_x = '0;
   logic acc_busy, add_busy, add2_busy, acc2_busy, acc3_busy, acc4_busy, switch_test_busy, test_busy;
   logic [31:0] acc_return, add_return, add2_return, acc2_return, acc3_return, acc4_return;
   logic [31:0] switch_test_return;
   logic test_return;

   typedef struct {int m; int val; int cyc;} exp_t;
   exp_t sbq[$];
   int checks = 0;
   int failures = 0;
   int xm = 0;

   always #5 clk = ~clk;

   assign busy_v = {test_busy, switch_test_busy, acc4_busy, acc3_busy,
                    acc2_busy, add2_busy, add_busy, acc_busy};

   test_001 dut (
      .clk(clk), .reset(reset),
      .acc_req(req_v[ACC]), .add_req(req_v[ADD]), .add2_req(req_v[ADD2]),
      .acc2_req(req_v[ACC2]), .acc3_req(req_v[ACC3]), .acc4_req(req_v[ACC4]),
      .switch_test_req(req_v[SW]), .test_req(req_v[TST]),
      .acc_y(acc_y), .add_x(add_x), .add_y(add_y), .add2_x(add2_x), .add2_y(add2_y),
      .acc2_num(acc2_num), .acc2_y(acc2_y), .acc3_num(acc3_num), .acc3_y(acc3_y),
      .acc4_num(acc4_num), .acc4_y(acc4_y), .switch_test_x(switch_test_x),
      .acc_busy(acc_busy), .add_busy(add_busy), .add2_busy(add2_busy),
      .acc2_busy(acc2_busy), .acc3_busy(acc3_busy), .acc4_busy(acc4_busy),
      .switch_test_busy(switch_test_busy), .test_busy(test_busy),
      .acc_return(acc_return), .add_return(add_return), .add2_return(add2_return),
      .acc2_return(acc2_return), .acc3_return(acc3_return), .acc4_return(acc4_return),
      .switch_test_return(switch_test_return), .test_return(test_return)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ret_of(input int m);
      case (m)
         ACC:     return acc_return;
         ADD:     return add_return;
         ADD2:    return add2_return;
         ACC2:    return acc2_return;
         ACC3:    return acc3_return;
         ACC4:    return acc4_return;
         SW:      return switch_test_return;
         default: return {31'b0, test_return};
      endcase
   endfunction

   // Reference model: returns the result and the expected number of busy cycles
   // (execute cycles plus the completion cycle; 0 = only bound-checked).
   function automatic int model(input int m, input int a, input int b, output int cyc);
      int r, it, d;
      bit ok;
      r = 0; it = 0; cyc = 2;
      case (m)
         ACC:  begin xm = xm + a; r = xm; end
         ADD:  r = a + b;
         ADD2: r = a + 2 * b;
         SW:   r = (a == 0) ? 10 : (a == 1) ? 20 : (a == 2) ? 30 : -1;
         ACC2: begin
            for (int i = 0; i < a; i++) begin xm = xm + b; it++; end
            r = xm; cyc = ((it == 0) ? 1 : it) + 1;
         end
         ACC3: begin
            for (int i = 0; i < a; i++) begin xm = xm + b + i; it++; end
            r = xm; cyc = ((it == 0) ? 1 : it) + 1;
         end
         ACC4: begin
            for (int i = 0; i < a; i++) begin
               xm = xm + b; it++;
               if (xm > 1000) break;
            end
            r = xm; cyc = ((it == 0) ? 1 : it) + 1;
         end
         default: begin
            xm = 0;
            ok = (model(ACC, 5, 0, d) == 5);
            ok = ok && (model(ACC2, 3, 2, d) == 11);
            ok = ok && (model(ACC3, 3, 1, d) == 17);
            ok = ok && (model(ACC4, 4, 3, d) == 29);
            ok = ok && (model(ADD, 2, 3, d) == 5);
            ok = ok && (model(ADD2, 2, 3, d) == 8);
            ok = ok && (model(SW, 1, 0, d) == 20);
            ok = ok && (model(SW, 7, 0, d) == -1);
            r = ok ? 1 : 0; cyc = 0;
         end
      endcase
      return r;
   endfunction

   task automatic set_args(input int m, input int a, input int b);
      case (m)
         ACC:  acc_y = a;
         ADD:  begin add_x = a; add_y = b; end
         ADD2: begin add2_x = a; add2_y = b; end
         ACC2: begin acc2_num = a; acc2_y = b; end
         ACC3: begin acc3_num = a; acc3_y = b; end
         ACC4: begin acc4_num = a; acc4_y = b; end
         SW:   switch_test_x = a;
         default: ;
      endcase
   endtask

   task automatic scramble_args();
      acc_y = $urandom; add_x = $urandom; add_y = $urandom; add2_x = $urandom;
      add2_y = $urandom; acc2_num = $urandom; acc2_y = $urandom; acc3_num = $urandom;
      acc3_y = $urandom; acc4_num = $urandom; acc4_y = $urandom; switch_test_x = $urandom;
   endtask

   task automatic push_exp(input int m, input int a, input int b);
      exp_t e;
      int cyc;
      e.val = model(m, a, b, cyc);
      e.m = m;
      e.cyc = cyc;
      sbq.push_back(e);
   endtask

   task automatic wait_busy(input int m, input logic lvl, input int limit, output int w);
      w = 0;
      while (busy_v[m] !== lvl && w < limit) begin @(negedge clk); w++; end
   endtask

   task automatic do_call(input int m, input int a, input int b);
      int w;
      @(negedge clk);
      set_args(m, a, b);
      push_exp(m, a, b);
      req_v[m] = 1'b1;
      @(negedge clk);
      wait_busy(m, 1'b1, 3, w);
      check("busy_rise_within_2", {31'b0, busy_v[m] === 1'b1 && w <= 1}, 32'd1);
      req_v[m] = 1'b0;
      scramble_args();
      wait_busy(m, 1'b0, 300, w);
      check("busy_fall", {31'b0, busy_v[m]}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_v = '0;
      sbq.delete();
      xm = 0;
      repeat (2) @(negedge clk);
      check("reset_busy", {24'b0, busy_v}, 32'd0);
      for (int m = 0; m < 8; m++) check("reset_return", ret_of(m), 32'd0);
      reset = 1'b0;
   endtask

   // Monitor: a falling busy marks a completion; pop and compare
   initial begin
      logic [7:0] prev;
      int cnt;
      exp_t e;
      prev = '0;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = '0;
            cnt = 0;
         end else begin
            if (busy_v != 8'b0) cnt++;
            for (int m = 0; m < 8; m++) begin
               if (prev[m] && !busy_v[m]) begin
                  if (sbq.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_completion: method=%0d with empty scoreboard", m);
                  end else begin
                     e = sbq.pop_front();
                     check("completed_method", m, e.m);
                     check("return_value", ret_of(m), e.val);
                     if (e.cyc > 0) check("busy_cycles", cnt, e.cyc);
                     else check("test_cycles_under_100", {31'b0, cnt < 100 && cnt > 0}, 32'd1);
                  end
                  cnt = 0;
               end
            end
            prev = busy_v;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int m, a, b, w;
      do_reset();

      // Built-in self-test, then reset clears its return
      do_call(TST, 0, 0);
      do_reset();

      do_call(ACC, 7, 0);
      do_call(ACC, -3, 0);

      do_reset();
      do_call(ACC2, 0, 9);
      do_call(ACC2, -1, 9);
      do_call(ACC3, 2, 10);

      do_reset();
      do_call(ACC4, 1000, 600);

      do_call(SW, 0, 0);
      do_call(SW, 2, 0);
      do_call(SW, 3, 0);
      do_call(SW, -1, 0);
      do_call(ADD, 32'h7FFF_FFFF, 1);

      // Simultaneous add and acc: acc wins, add follows while held
      do_reset();
      @(negedge clk);
      set_args(ACC, 10, 0);
      set_args(ADD, 2, 3);
      push_exp(ACC, 10, 0);
      push_exp(ADD, 2, 3);
      req_v[ACC] = 1'b1;
      req_v[ADD] = 1'b1;
      @(negedge clk);
      wait_busy(ACC, 1'b1, 3, w);
      check("priority_acc_busy", {31'b0, acc_busy}, 32'd1);
      check("priority_add_waiting", {31'b0, add_busy}, 32'd0);
      req_v[ACC] = 1'b0;
      wait_busy(ADD, 1'b1, 20, w);
      check("held_add_runs", {31'b0, add_busy}, 32'd1);
      req_v[ADD] = 1'b0;
      wait_busy(ADD, 1'b0, 20, w);

      // Reset mid-call aborts acc2 with no return update
      @(negedge clk);
      set_args(ACC2, 20, 1);
      req_v[ACC2] = 1'b1;
      @(negedge clk);
      req_v[ACC2] = 1'b0;
      repeat (3) @(negedge clk);
      do_reset();
      do_call(ACC, 1, 0);

      for (int n = 0; n < 120; n++) begin
         m = $urandom_range(0, 7);
         a = $urandom;
         b = $urandom;
         if (m == ACC2 || m == ACC3 || m == ACC4) begin
            a = $urandom_range(0, 15) - 3;
            if (m != ACC2) b = $urandom_range(0, 800) - 400;
         end else if (m == SW) begin
            a = $urandom_range(0, 5) - 1;
         end
         do_call(m, a, b);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
